fft_bin_mul_sched: RTL and testbench
====================================

// Module: fft_bin_mul_sched
// PURPOSE
//  Sequences the pointwise-product stage of the FFT multiplier. Holds one
//  snapshot of both forward-FFT spectra, feeds bins one per cycle through a
//  single shared pipelined complex multiplier, and collects the products
//  into a result spectrum. The result spectrum is handed to the ifft stage.
//  This block replaces the eight parallel mul_complex instances with one.
// PARAMETERS
//  W        32  bit width of each real/imag word (signed, 16.16 fixed point)
//  NBIN     8   number of FFT bins; index width is clog2(NBIN)
//  MUL_LAT  2   cycles from a cm_valid issue to its cm_pr/cm_pi result; legal range >=1
// PORTS
//  clk      in   1         clock, rising edge
//  rst      in   1         asynchronous reset, active-high
//  start    in   1         request a new schedule; sampled only in IDLE
//  busy     out  1         high while a schedule is in progress
//  done     out  1         one-cycle pulse; zr_bus/zi_bus are complete
//  xr_bus   in   NBIN*W    X spectrum real part; bin k at [k*W +: W]
//  xi_bus   in   NBIN*W    X spectrum imag part
//  yr_bus   in   NBIN*W    Y spectrum real part
//  yi_bus   in   NBIN*W    Y spectrum imag part
//  cm_valid out  1         operand issue to the shared complex multiplier
//  cm_ar    out  W         operand A real part = xr[k]
//  cm_ai    out  W         operand A imag part = xi[k]
//  cm_br    out  W         operand B real part = yr[k]
//  cm_bi    out  W         operand B imag part = yi[k]
//  cm_pr    in   W         product real part, valid MUL_LAT cycles after its issue
//  cm_pi    in   W         product imag part
//  zr_bus   out  NBIN*W    product spectrum real part, registered
//  zi_bus   out  NBIN*W    product spectrum imag part, registered
// BEHAVIOUR
//  Reset (async): state=IDLE; busy, done, cm_valid, all cm_a*/cm_b* = 0;
//   zr_bus/zi_bus = 0; return tracker cleared. Reset mid-schedule aborts it:
//   no done pulse, partial products are discarded.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//   IDLE : start=1 at edge E0 -> snapshot all four input buses into internal
//          registers; issue index k=0; go to ISSUE. Input buses are don't-care
//          after E0.
//   ISSUE: cm_valid=1; cm_* = snapshot bin k; k increments each cycle.
//          Issues occupy cycles 1..NBIN after E0. Leave after k=NBIN-1.
//   DRAIN: cm_valid=0. Stay until the return tracker is empty.
//   DONE : done=1 for exactly one cycle; next state is IDLE.
//  Return tracker: a MUL_LAT-deep shift register of {valid, k}. When an entry
//   exits with valid=1, cm_pr/cm_pi are written into bin k of zr_bus/zi_bus at
//   that edge. Bins that are not written keep their previous value.
//  Timing: the bin issued in cycle c is captured at the end of cycle c+MUL_LAT.
//   The last capture is at the end of cycle NBIN+MUL_LAT. done is high in cycle
//   NBIN+MUL_LAT+1. Total start-to-done = NBIN+MUL_LAT+1 cycles (11 with defaults).
//  busy: high from cycle 1 through the DONE cycle; low in IDLE.
//  start while busy=1 is ignored, not queued. start in the DONE cycle is also
//   ignored; back-to-back schedules are therefore spaced by one IDLE cycle.
//  cm_a*/cm_b* are driven 0 whenever cm_valid=0.
//  No arithmetic in this block; words pass unmodified, sign bits preserved.
// TESTING
//  1. Reset, then start with bin k: xr=k+1, yr=2, all imag=0; 2-cycle
//     multiplier model -> done in cycle 11, zr[k]=2(k+1), zi=0.
//  2. cm_valid pattern: high exactly cycles 1..8 after start, cm_ar=k+1 in
//     cycle k+1; busy high cycles 1..11, done high only in cycle 11.
//  3. Change all input buses in the cycle after start -> results reflect
//     the snapshot values only.
//  4. Hold start high continuously -> schedules begin every 12 cycles
//     (11 busy + 1 IDLE); no start is lost mid-run and none is double-counted.
//  5. Assert rst in cycle 5 of a run -> busy, done, cm_valid, z buses go to 0
//     immediately; no done pulse; next start gives correct results.
//  6. MUL_LAT=1 and MUL_LAT=5 builds with negative operands, xr=-3, yr=-4
//     -> zr=12; done at cycles 10 and 14 respectively.

Source files
------------

// File: rtl/fft_bin_mul_sched.sv
// fft_bin_mul_sched: feeds snapshot spectrum bins through one shared pipelined complex multiplier and collects the products
//  start/busy/done  schedule handshake (done is a one-cycle pulse)
//  x*/y*_bus        input spectra, bin k at [k*W +: W], snapshotted on accepted start
//  cm_*             shared multiplier issue (valid + operands) and product return
//  zr_bus/zi_bus    registered product spectrum
module fft_bin_mul_sched #(
  parameter int W       = 32,
  parameter int NBIN    = 8,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [NBIN*W-1:0] xr_bus,
  input  logic [NBIN*W-1:0] xi_bus,
  input  logic [NBIN*W-1:0] yr_bus,
  input  logic [NBIN*W-1:0] yi_bus,
  output logic              cm_valid,
  output logic [W-1:0]      cm_ar,
  output logic [W-1:0]      cm_ai,
  output logic [W-1:0]      cm_br,
  output logic [W-1:0]      cm_bi,
  input  logic [W-1:0]      cm_pr,
  input  logic [W-1:0]      cm_pi,
  output logic [NBIN*W-1:0] zr_bus,
  output logic [NBIN*W-1:0] zi_bus
);
  localparam int KW = $clog2(NBIN);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] xr_q [NBIN], xi_q [NBIN], yr_q [NBIN], yi_q [NBIN];
  logic [W-1:0] zr_q [NBIN], zi_q [NBIN];
  logic [MUL_LAT-1:0] tv_q, tv_sh;
  logic [KW-1:0] tk_q [MUL_LAT];
  logic load;
  // tv_sh drops the exiting stage: anything left is still in flight after this edge
  always_comb begin
    load    = state_q == IDLE && start;
    tv_sh   = tv_q << 1;
    state_d = state_q == IDLE  ? (start ? ISSUE : IDLE) :
              state_q == ISSUE ? (k_q == KW'(NBIN - 1) ? DRAIN : ISSUE) :
              state_q == DRAIN ? (|tv_sh ? DRAIN : DONE) : IDLE;
    k_d     = state_q == ISSUE ? k_q + 1'b1 : '0;
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign cm_valid = state_q == ISSUE;
  assign cm_ar    = cm_valid ? xr_q[k_q] : '0;
  assign cm_ai    = cm_valid ? xi_q[k_q] : '0;
  assign cm_br    = cm_valid ? yr_q[k_q] : '0;
  assign cm_bi    = cm_valid ? yi_q[k_q] : '0;
  for (genvar g = 0; g < NBIN; g++) begin : g_z
    assign zr_bus[g*W +: W] = zr_q[g];
    assign zi_bus[g*W +: W] = zi_q[g];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      tv_q    <= '0;
      for (int i = 0; i < MUL_LAT; i++) tk_q[i] <= '0;
      for (int i = 0; i < NBIN; i++) begin
        xr_q[i] <= '0;
        xi_q[i] <= '0;
        yr_q[i] <= '0;
        yi_q[i] <= '0;
        zr_q[i] <= '0;
        zi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tv_q    <= tv_sh | MUL_LAT'(cm_valid);
      for (int i = MUL_LAT - 1; i > 0; i--) tk_q[i] <= tk_q[i-1];
      tk_q[0] <= k_q;
      if (load)
        for (int i = 0; i < NBIN; i++) begin
          xr_q[i] <= xr_bus[i*W +: W];
          xi_q[i] <= xi_bus[i*W +: W];
          yr_q[i] <= yr_bus[i*W +: W];
          yi_q[i] <= yi_bus[i*W +: W];
        end
      if (tv_q[MUL_LAT-1]) begin
        zr_q[tk_q[MUL_LAT-1]] <= cm_pr;
        zi_q[tk_q[MUL_LAT-1]] <= cm_pi;
      end
    end
  end
endmodule

// File: tb/tb_fft_bin_mul_sched.sv
// tb_fft_bin_mul_sched: directed bench for fft_bin_mul_sched at MUL_LAT 2, 1 and 5
module tb_fft_bin_mul_sched;
  logic clk = 0, rst = 1;
  logic [255:0] xr, xi, yr, yi;
  logic st [3];
  logic bz [3], dn [3], cv [3];
  logic [31:0] car [3], cbr [3];
  logic [255:0] zr [3], zi [3];
  int total = 0, pass = 0;
  always #5 clk = ~clk;
  function automatic logic [63:0] cmul(input logic signed [31:0] ar, ai, br, bi);
    logic signed [31:0] re, im;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re, im};
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 2 : g == 1 ? 1 : 5;
    logic [63:0] pipe [L];
    logic [31:0] ai, bi;
    fft_bin_mul_sched #(.W(32), .NBIN(8), .MUL_LAT(L)) dut (
      .clk(clk), .rst(rst), .start(st[g]), .busy(bz[g]), .done(dn[g]),
      .xr_bus(xr), .xi_bus(xi), .yr_bus(yr), .yi_bus(yi),
      .cm_valid(cv[g]), .cm_ar(car[g]), .cm_ai(ai), .cm_br(cbr[g]), .cm_bi(bi),
      .cm_pr(pipe[L-1][63:32]), .cm_pi(pipe[L-1][31:0]),
      .zr_bus(zr[g]), .zi_bus(zi[g]));
    always @(posedge clk) begin
      pipe[0] <= cmul(car[g], ai, cbr[g], bi);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic set_bus(input int mode);
    for (int k = 0; k < 8; k++) begin
      xr[k*32 +: 32] = mode == 2 ? 32'hdead0000 + k : mode == 3 ? -32'sd3 : 32'(k + 1);
      xi[k*32 +: 32] = mode == 1 ? 32'd1 : mode == 2 ? 32'h77 : 32'd0;
      yr[k*32 +: 32] = mode == 2 ? 32'h1234 : mode == 3 ? -32'sd4 : 32'd2;
      yi[k*32 +: 32] = mode == 1 ? -32'sd1 : mode == 2 ? 32'h55 : 32'd0;
    end
  endtask
  task automatic go(input int s, input bit scramble, output int dc);
    @(posedge clk); #1 st[s] = 1;
    @(posedge clk); #1 st[s] = 0;
    if (scramble) set_bus(2);
    dc = -1;
    for (int c = 1; c <= 25 && dc < 0; c++) begin
      @(negedge clk);
      if (dn[s]) dc = c;
    end
  endtask
  task automatic chk_z(input int s, input int mode);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("zr%0d[%0d]", s, k), zr[s][k*32 +: 32],
          mode == 0 ? 32'(2 * (k + 1)) : mode == 1 ? 32'(2 * k + 3) : mode == 3 ? 32'd12 : 32'd0);
      chk($sformatf("zi%0d[%0d]", s, k), zi[s][k*32 +: 32], mode == 1 ? 32'(1 - k) : 32'd0);
    end
  endtask
  initial begin
    int dc, nd;
    for (int i = 0; i < 3; i++) st[i] = 0;
    set_bus(0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_valid", 32'(cv[0]), 0);
    chk("rst_ar", car[0], 0);
    chk_z(0, 4);
    rst = 0;
    @(posedge clk); #1 st[0] = 1;
    @(posedge clk); #1 st[0] = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("valid_c%0d", c), 32'(cv[0]), 32'(c <= 8));
      chk($sformatf("ar_c%0d", c), car[0], c <= 8 ? 32'(c) : 32'd0);
      chk($sformatf("br_c%0d", c), cbr[0], c <= 8 ? 32'd2 : 32'd0);
      chk($sformatf("busy_c%0d", c), 32'(bz[0]), 32'(c <= 11));
      chk($sformatf("done_c%0d", c), 32'(dn[0]), 32'(c == 11));
    end
    chk_z(0, 0);
    set_bus(1);
    go(0, 1, dc);
    chk("snap_done_cyc", 32'(dc), 11);
    chk_z(0, 1);
    set_bus(0);
    @(posedge clk); #1 st[0] = 1;
    @(posedge clk);
    nd = 0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      chk($sformatf("hold_busy_%0d", n), 32'(bz[0]), 32'(n % 12 != 0));
      chk($sformatf("hold_done_%0d", n), 32'(dn[0]), 32'(n % 12 == 11));
      nd += int'(dn[0]);
    end
    st[0] = 0;
    chk("hold_ndone", 32'(nd), 3);
    chk_z(0, 0);
    @(posedge clk); #1 st[0] = 1;
    @(posedge clk); #1 st[0] = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_busy", 32'(bz[0]), 0);
    chk("midrst_valid", 32'(cv[0]), 0);
    chk("midrst_done", 32'(dn[0]), 0);
    chk_z(0, 4);
    @(negedge clk); rst = 0;
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      nd += int'(dn[0]);
    end
    chk("midrst_no_done", 32'(nd), 0);
    go(0, 0, dc);
    chk("after_rst_done_cyc", 32'(dc), 11);
    chk_z(0, 0);
    set_bus(3);
    go(1, 0, dc);
    chk("lat1_done_cyc", 32'(dc), 10);
    chk_z(1, 3);
    go(2, 0, dc);
    chk("lat5_done_cyc", 32'(dc), 14);
    chk_z(2, 3);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
